mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/mem_arb_grant.sv | 38 +++
 rtl/mem_arbiter.sv | 137 +++++++++++++
 tb/tb_mem_arbiter.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the fetch/execute memory arbiter.
// MEM_ARB_FAIR_EN (when defined) enables alternating grants under contention.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACC_IF = 2'd1,
        ACC_EX = 2'd2
    } state_t;

    typedef enum logic {
        PORT_IF = 1'b0,
        PORT_EX = 1'b1
    } port_t;

    // Width of the access-length down-counter; MEM_LATENCY must fit in it.
    localparam int LAT_W = 4;

endpackage

// File: rtl/mem_arb_grant.sv
// Combinational grant decision between the fetch and execute requesters.
// MEM_ARB_FAIR_EN adds a last-grant input that alternates the winner under contention.
module mem_arb_grant
    import mem_arb_pkg::*;
(
    input  logic  if_req,
    input  logic  if_flush,
    input  logic  if_ready,
    input  logic  ex_req,
    input  logic  ex_ready,
`ifdef MEM_ARB_FAIR_EN
    input  port_t last_grant,
`endif
    output logic  grant_valid,
    output port_t grant_port
);

    logic if_pend;
    logic ex_pend;

    // A port finishing this cycle still shows req high; it is not a new request.
    assign if_pend = if_req & ~if_flush & ~if_ready;
    assign ex_pend = ex_req & ~ex_ready;

    always_comb begin
        grant_valid = if_pend | ex_pend;
        grant_port  = PORT_EX;
        if (if_pend && !ex_pend) begin
            grant_port = PORT_IF;
        end
`ifdef MEM_ARB_FAIR_EN
        else if (if_pend && ex_pend && last_grant == PORT_EX) begin
            grant_port = PORT_IF;
        end
`endif
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester (fetch / execute) arbiter for a shared single-port memory.
// Define MEM_ARB_FAIR_EN for alternating grants under contention; otherwise execute always wins.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH  = 12,
    parameter int WORD_WIDTH  = 32,
    parameter int MEM_LATENCY = 1
)(
    input  logic                  i_clk,
    input  logic                  i_rst_n,

    input  logic                  i_if_req,
    input  logic [ADDR_WIDTH-1:0] i_if_addr,
    input  logic                  i_if_flush,
    output logic                  o_if_ready,
    output logic [WORD_WIDTH-1:0] o_if_data,
    output logic                  o_if_stall,

    input  logic                  i_ex_req,
    input  logic                  i_ex_we,
    input  logic [ADDR_WIDTH-1:0] i_ex_addr,
    input  logic [WORD_WIDTH-1:0] i_ex_wdata,
    output logic                  o_ex_ready,
    output logic [WORD_WIDTH-1:0] o_ex_rdata,
    output logic                  o_ex_stall,

    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic                  o_mem_write,
    output logic [WORD_WIDTH-1:0] o_mem_wdata,
    input  logic [WORD_WIDTH-1:0] i_mem_data
);

    localparam logic [LAT_W-1:0] LAT_CNT  = LAT_W'(MEM_LATENCY);
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(1);

    state_t           state;
    logic [LAT_W-1:0] cnt;
    logic             flushed;
    logic             grant_valid;
    port_t            grant_port;
`ifdef MEM_ARB_FAIR_EN
    port_t            last_grant;
`endif

    mem_arb_grant u_grant (
        .if_req      (i_if_req),
        .if_flush    (i_if_flush),
        .if_ready    (o_if_ready),
        .ex_req      (i_ex_req),
        .ex_ready    (o_ex_ready),
`ifdef MEM_ARB_FAIR_EN
        .last_grant  (last_grant),
`endif
        .grant_valid (grant_valid),
        .grant_port  (grant_port)
    );

    assign o_if_stall = i_if_req & ~o_if_ready;
    assign o_ex_stall = i_ex_req & ~o_ex_ready;

    // o_mem_write doubles as the latched write-enable of the execute access in flight.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            flushed     <= 1'b0;
            o_if_ready  <= 1'b0;
            o_ex_ready  <= 1'b0;
            o_if_data   <= '0;
            o_ex_rdata  <= '0;
            o_mem_addr  <= '0;
            o_mem_write <= 1'b0;
            o_mem_wdata <= '0;
`ifdef MEM_ARB_FAIR_EN
            last_grant  <= PORT_IF;
`endif
        end else begin
            o_if_ready <= 1'b0;
            o_ex_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        cnt     <= LAT_CNT;
                        flushed <= 1'b0;
`ifdef MEM_ARB_FAIR_EN
                        last_grant <= grant_port;
`endif
                        if (grant_port == PORT_EX) begin
                            state       <= ACC_EX;
                            o_mem_addr  <= i_ex_addr;
                            o_mem_wdata <= i_ex_wdata;
                            o_mem_write <= i_ex_we;
                        end else begin
                            state       <= ACC_IF;
                            o_mem_addr  <= i_if_addr;
                            o_mem_write <= 1'b0;
                        end
                    end
                end
                ACC_IF: begin
                    // A flush anywhere in the access, including its last cycle, drops the result.
                    if (cnt == LAT_LAST) begin
                        state <= IDLE;
                        cnt   <= '0;
                        if (!(flushed || i_if_flush)) begin
                            o_if_ready <= 1'b1;
                            o_if_data  <= i_mem_data;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                        if (i_if_flush) begin
                            flushed <= 1'b1;
                        end
                    end
                end
                ACC_EX: begin
                    if (cnt == LAT_LAST) begin
                        state       <= IDLE;
                        cnt         <= '0;
                        o_mem_write <= 1'b0;
                        o_ex_ready  <= 1'b1;
                        if (!o_mem_write) begin
                            o_ex_rdata <= i_mem_data;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic
// checked every cycle against a schedule-based reference model.
module tb_mem_arbiter;

    localparam int AW   = 12;
    localparam int WW   = 32;
    localparam int LAT  = 1;
    localparam int LAT3 = 3;

    logic i_clk   = 1'b0;
    logic i_rst_n = 1'b0;

    logic          if_req, if_flush, ex_req, ex_we;
    logic [AW-1:0] if_addr, ex_addr;
    logic [WW-1:0] ex_wdata;
    logic          if_ready, if_stall, ex_ready, ex_stall, mem_write;
    logic [WW-1:0] if_data, ex_rdata, mem_wdata, mem_rdata;
    logic [AW-1:0] mem_addr;

    logic          ex3_req;
    logic [AW-1:0] ex3_addr;
    logic          if3_ready, if3_stall, ex3_ready, ex3_stall, mem3_write;
    logic [WW-1:0] if3_data, ex3_rdata, mem3_wdata, mem3_rdata;
    logic [AW-1:0] mem3_addr;

    int n_vec = 0;
    int n_err = 0;

    always #5 i_clk = ~i_clk;

    mem_arbiter #(.ADDR_WIDTH(AW), .WORD_WIDTH(WW), .MEM_LATENCY(LAT)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_if_req(if_req), .i_if_addr(if_addr), .i_if_flush(if_flush),
        .o_if_ready(if_ready), .o_if_data(if_data), .o_if_stall(if_stall),
        .i_ex_req(ex_req), .i_ex_we(ex_we), .i_ex_addr(ex_addr), .i_ex_wdata(ex_wdata),
        .o_ex_ready(ex_ready), .o_ex_rdata(ex_rdata), .o_ex_stall(ex_stall),
        .o_mem_addr(mem_addr), .o_mem_write(mem_write), .o_mem_wdata(mem_wdata),
        .i_mem_data(mem_rdata)
    );

    mem_arbiter #(.ADDR_WIDTH(AW), .WORD_WIDTH(WW), .MEM_LATENCY(LAT3)) dut3 (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_if_req(1'b0), .i_if_addr('0), .i_if_flush(1'b0),
        .o_if_ready(if3_ready), .o_if_data(if3_data), .o_if_stall(if3_stall),
        .i_ex_req(ex3_req), .i_ex_we(1'b0), .i_ex_addr(ex3_addr), .i_ex_wdata('0),
        .o_ex_ready(ex3_ready), .o_ex_rdata(ex3_rdata), .o_ex_stall(ex3_stall),
        .o_mem_addr(mem3_addr), .o_mem_write(mem3_write), .o_mem_wdata(mem3_wdata),
        .i_mem_data(mem3_rdata)
    );

    function automatic logic [WW-1:0] init_word(input int a);
        if (a == 4) return 32'hF088_0000;
        return (32'(a) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    // Environment memory: combinational read, written by the DUT's write strobe.
    logic [WW-1:0] env_mem [0:4095];
    bit            env_init = 1'b0;
    assign mem_rdata  = env_mem[mem_addr];
    assign mem3_rdata = 32'h1000_0000 | WW'(mem3_addr);

    always @(posedge i_clk) begin
        if (!env_init) begin
            for (int i = 0; i < 4096; i++) env_mem[i] <= init_word(i);
            env_init <= 1'b1;
        end else if (mem_write) begin
            env_mem[mem_addr] <= mem_wdata;
        end
    end

    task automatic check_output(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: each grant at cycle c owns the port for cycles c+1..c+LAT,
    // and its completion (if not flushed) is visible at cycle c+LAT+1.
    logic [WW-1:0] ref_mem [0:4095];
    bit            ref_init = 1'b0;
    int            cyc = 0;
    bit            m_busy, m_is_ex, m_we, m_flushed;
    logic [AW-1:0] m_addr;
    logic [WW-1:0] m_wdata;
    int            m_end, if_rdy_at, ex_rdy_at;
    logic [AW-1:0] e_mem_addr;
    logic [WW-1:0] e_wdata, e_if_data, e_ex_rdata;
`ifdef MEM_ARB_FAIR_EN
    bit            m_last_ex;
`endif

    always @(negedge i_clk) begin
        bit e_if_rdy, e_ex_rdy, e_wr, if_ok, ex_ok, pick_ex;
        if (!ref_init) begin
            for (int i = 0; i < 4096; i++) ref_mem[i] = init_word(i);
            ref_init = 1'b1;
        end
        cyc++;
        if (!i_rst_n) begin
            m_busy = 0; m_flushed = 0; if_rdy_at = -1; ex_rdy_at = -1;
            e_mem_addr = '0; e_wdata = '0; e_if_data = '0; e_ex_rdata = '0;
`ifdef MEM_ARB_FAIR_EN
            m_last_ex = 0;
`endif
        end
        e_if_rdy = i_rst_n && (if_rdy_at == cyc);
        e_ex_rdy = i_rst_n && (ex_rdy_at == cyc);
        e_wr     = i_rst_n && m_busy && m_is_ex && m_we;
        check_output("if_ready",  if_ready,  e_if_rdy);
        check_output("ex_ready",  ex_ready,  e_ex_rdy);
        check_output("if_data",   if_data,   e_if_data);
        check_output("ex_rdata",  ex_rdata,  e_ex_rdata);
        check_output("mem_addr",  mem_addr,  e_mem_addr);
        check_output("mem_write", mem_write, e_wr);
        check_output("mem_wdata", mem_wdata, e_wdata);
        check_output("if_stall",  if_stall,  if_req & ~e_if_rdy);
        check_output("ex_stall",  ex_stall,  ex_req & ~e_ex_rdy);
        if (i_rst_n) begin
            if (m_busy) begin
                if (!m_is_ex && if_flush) m_flushed = 1;
                if (cyc == m_end) begin
                    m_busy = 0;
                    if (m_is_ex) begin
                        ex_rdy_at = cyc + 1;
                        if (m_we) ref_mem[m_addr] = m_wdata;
                        else      e_ex_rdata = ref_mem[m_addr];
                    end else if (!m_flushed) begin
                        if_rdy_at = cyc + 1;
                        e_if_data = ref_mem[m_addr];
                    end
                end
            end else begin
                if_ok   = if_req && !if_flush && !e_if_rdy;
                ex_ok   = ex_req && !e_ex_rdy;
                pick_ex = ex_ok;
`ifdef MEM_ARB_FAIR_EN
                if (if_ok && ex_ok && m_last_ex) pick_ex = 0;
`endif
                if (if_ok || ex_ok) begin
`ifdef MEM_ARB_FAIR_EN
                    m_last_ex = pick_ex;
`endif
                    m_busy = 1; m_is_ex = pick_ex; m_end = cyc + LAT; m_flushed = 0;
                    if (pick_ex) begin
                        m_addr = ex_addr; m_we = ex_we; m_wdata = ex_wdata; e_wdata = ex_wdata;
                    end else begin
                        m_addr = if_addr; m_we = 0;
                    end
                    e_mem_addr = m_addr;
                end
            end
        end
    end

    bit seen_if_ready, seen_ex_ready, seen_flush;

    task automatic tick();
        seen_if_ready = if_ready;
        seen_ex_ready = ex_ready;
        seen_flush    = if_flush;
        @(posedge i_clk);
        #1;
    endtask

    task automatic apply_stimulus();
        if (if_req && (seen_if_ready || seen_flush)) if_req = 1'b0;
        else if (!if_req && $urandom_range(0, 1) == 1) begin
            if_req  = 1'b1;
            if_addr = AW'($urandom_range(0, 15) * 4);
        end
        if (ex_req && seen_ex_ready) ex_req = 1'b0;
        else if (!ex_req && $urandom_range(0, 2) != 0) begin
            ex_req   = 1'b1;
            ex_we    = 1'($urandom_range(0, 1));
            ex_addr  = AW'($urandom_range(0, 15) * 4);
            ex_wdata = $urandom;
        end
        if_flush = ($urandom_range(0, 9) == 0);
    endtask

    initial begin
        if_req = 0; if_flush = 0; ex_req = 0; ex_we = 0;
        if_addr = '0; ex_addr = '0; ex_wdata = '0;
        ex3_req = 0; ex3_addr = '0;
        repeat (3) @(posedge i_clk);
        #1 i_rst_n = 1'b1;

        // Fetch-only read
        tick(); if_req = 1; if_addr = 12'h004;
        @(negedge i_clk) check_output("r030_c0_ready", if_ready, 1'b0);
        tick(); @(negedge i_clk);
        check_output("r030_c1_addr", mem_addr, 32'h004);
        check_output("r030_c1_write", mem_write, 1'b0);
        tick(); @(negedge i_clk);
        check_output("r030_c2_ready", if_ready, 1'b1);
        check_output("r030_c2_data", if_data, 32'hF088_0000);
        tick(); if_req = 0;

        // Simultaneous fetch and store: store first
        tick(); if_req = 1; if_addr = 12'h008; ex_req = 1; ex_we = 1; ex_addr = 12'h100; ex_wdata = 32'hA;
        tick(); @(negedge i_clk);
        check_output("r031_c1_write", mem_write, 1'b1);
        check_output("r031_c1_addr", mem_addr, 32'h100);
        tick(); @(negedge i_clk);
        check_output("r031_c2_exrdy", ex_ready, 1'b1);
        check_output("r031_c2_write", mem_write, 1'b0);
        tick(); ex_req = 0; ex_we = 0;
        @(negedge i_clk) check_output("r031_c3_addr", mem_addr, 32'h008);
        tick(); @(negedge i_clk);
        check_output("r031_c4_ifrdy", if_ready, 1'b1);
        check_output("r031_c4_data", if_data, init_word(8));
        tick(); if_req = 0;
        check_output("r031_stored", env_mem[12'h100], 32'hA);

        // Both held: EX, IF, EX
        tick(); ex_req = 1; ex_we = 0; ex_addr = 12'h0C0; if_req = 1; if_addr = 12'h0D0;
        tick(); @(negedge i_clk) check_output("r032_g1", mem_addr, 32'h0C0);
        tick(); @(negedge i_clk) check_output("r032_exrdy", ex_ready, 1'b1);
        tick(); @(negedge i_clk) check_output("r032_g2", mem_addr, 32'h0D0);
        tick(); @(negedge i_clk) check_output("r032_ifrdy", if_ready, 1'b1);
        tick(); if_req = 0;
        @(negedge i_clk) check_output("r032_g3", mem_addr, 32'h0C0);
        tick(); @(negedge i_clk) check_output("r032_exrdy2", ex_ready, 1'b1);
        tick(); ex_req = 0;

        // Flush during fetch access
        tick(); if_req = 1; if_addr = 12'h010;
        tick(); if_flush = 1;
        @(negedge i_clk) check_output("r033_addr", mem_addr, 32'h010);
        tick(); if_flush = 0; if_req = 0;
        @(negedge i_clk) check_output("r033_noready", if_ready, 1'b0);
        tick(); if_req = 1; if_addr = 12'h008;
        tick();
        tick(); @(negedge i_clk);
        check_output("r033_ready", if_ready, 1'b1);
        check_output("r033_data", if_data, init_word(8));
        tick(); if_req = 0;

        // Latency-3 load on the second instance
        tick(); ex3_req = 1; ex3_addr = 12'h020;
        for (int k = 1; k <= 3; k++) begin
            tick(); @(negedge i_clk);
            check_output("r034_addr", mem3_addr, 32'h020);
            check_output("r034_early", ex3_ready, 1'b0);
        end
        tick(); @(negedge i_clk);
        check_output("r034_ready", ex3_ready, 1'b1);
        check_output("r034_data", ex3_rdata, 32'h1000_0020);
        tick(); ex3_req = 0;

        // Reset in the middle of a store
        tick(); ex_req = 1; ex_we = 1; ex_addr = 12'h040; ex_wdata = 32'h55;
        tick(); #1;
        check_output("r035_pre", mem_write, 1'b1);
        i_rst_n = 0; ex_req = 0; ex_we = 0;
        #1 check_output("r035_drop", mem_write, 1'b0);
        tick(); i_rst_n = 1;
        @(negedge i_clk) check_output("r035_norp1", ex_ready, 1'b0);
        tick(); @(negedge i_clk) check_output("r035_norp2", ex_ready, 1'b0);
        check_output("r035_mem", env_mem[12'h040], init_word(12'h040));

        // Randomized traffic
        for (int k = 0; k < 4000; k++) begin
            tick();
            apply_stimulus();
        end
        if_req = 0; ex_req = 0; if_flush = 0;
        repeat (4) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
